// File: rtl/hv_encoder_pkg.sv
// Shared select encodings and ALU operation codes for the hypervector encoder.
package hv_encoder_pkg;

    localparam int NumALUOps = 4;

    typedef enum logic [1:0] {
        ALU_OP_XOR  = 2'd0,
        ALU_OP_AND  = 2'd1,
        ALU_OP_OR   = 2'd2,
        ALU_OP_PERM = 2'd3   // circular left rotate of operand A
    } alu_op_e;

    // ALU operand selects; bundler k sits at ALU_SRC_BUND_BASE + k
    localparam int ALU_SRC_IM        = 0;
    localparam int ALU_SRC_REG       = 1;
    localparam int ALU_SRC_BUND_BASE = 2;

    // Bundler input selects; bundler j sits at BUND_SRC_BUND_BASE + j
    localparam int BUND_SRC_ALU       = 0;
    localparam int BUND_SRC_IM        = 1;
    localparam int BUND_SRC_REG       = 2;
    localparam int BUND_SRC_BUND_BASE = 3;

    // Register write-data selects
    localparam int REG_SRC_ALU       = 0;
    localparam int REG_SRC_IM        = 1;
    localparam int REG_SRC_BUND_BASE = 2;

    // Manual query-HV push selects
    localparam int QHV_SRC_ALU       = 0;
    localparam int QHV_SRC_REG       = 1;
    localparam int QHV_SRC_BUND_BASE = 2;

endpackage

// File: rtl/hv_encoder_mc_fifo.sv
// Query-HV output FIFO. Full is judged before any pop in the same cycle, so a
// push into a full FIFO is dropped and flagged even if the head leaves. The
// output holds the last head value while the FIFO is empty.
module hv_qhv_fifo #(
    parameter int Depth    = 4,
    parameter int Width    = 512,
    parameter int CntWidth = $clog2(Depth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic                clr_i,
    input  logic [Width-1:0]    data_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] cnt_o,
    output logic                drop_o
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [Width-1:0]    mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [Width-1:0]    hold_q, hold_d;
    logic                push_ok, pop_ok;

    assign full_o  = (cnt_q == CntFull);
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign push_ok = push_i && !full_o && !clr_i;
    assign pop_ok  = pop_i && !empty_o && !clr_i;
    assign drop_o  = push_i && full_o && !clr_i;
    assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

    // Next-state for storage, pointers, occupancy and the held head value
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        hold_d   = data_o;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CntOne;
                2'b01:   cnt_d = cnt_q - CntOne;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: rtl/hv_encoder_mc.sv
// Hypervector encoder datapath: ALU, register file, NumBund majority bundlers,
// and a query-HV output FIFO fed manually or by auto-emit from one bundler.
module hv_encoder_mc
    import hv_encoder_pkg::*;
#(
    parameter int HVDimension    = 512,
    parameter int NumBund        = 4,
    parameter int BundCountWidth = 8,
    parameter int RegNum         = 4,
    parameter int ALUMaxShiftAmt = 128,
    parameter int QhvFifoDepth   = 4,
    parameter int ALUMuxWidth    = $clog2(2 + NumBund),
    parameter int BundMuxWidth   = $clog2(3 + NumBund),
    parameter int RegMuxWidth    = $clog2(2 + NumBund),
    parameter int QvMuxWidth     = $clog2(2 + NumBund),
    parameter int RegAddrWidth   = $clog2(RegNum),
    parameter int BundSelWidth   = $clog2(NumBund),
    parameter int FifoCntWidth   = $clog2(QhvFifoDepth) + 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [HVDimension-1:0]                 im_rd_a_i,
    input  logic [HVDimension-1:0]                 im_rd_b_i,
    input  logic [ALUMuxWidth-1:0]                 alu_mux_a_i,
    input  logic [ALUMuxWidth-1:0]                 alu_mux_b_i,
    input  logic [$clog2(NumALUOps)-1:0]           alu_ops_i,
    input  logic [$clog2(ALUMaxShiftAmt)-1:0]      alu_shift_amt_i,
    input  logic [NumBund-1:0][BundMuxWidth-1:0]   bund_mux_i,
    input  logic [NumBund-1:0]                     bund_valid_i,
    input  logic [NumBund-1:0]                     bund_clr_i,
    input  logic [RegMuxWidth-1:0]                 reg_mux_i,
    input  logic [RegAddrWidth-1:0]                reg_rd_addr_a_i,
    input  logic [RegAddrWidth-1:0]                reg_rd_addr_b_i,
    input  logic [RegAddrWidth-1:0]                reg_wr_addr_i,
    input  logic                                   reg_wr_en_i,
    input  logic [QvMuxWidth-1:0]                  qhv_mux_i,
    input  logic                                   qhv_wen_i,
    input  logic                                   qhv_clr_i,
    input  logic                                   auto_emit_en_i,
    input  logic [BundSelWidth-1:0]                auto_emit_sel_i,
    input  logic [BundCountWidth-1:0]              auto_emit_count_i,
    input  logic                                   qhv_ready_i,
    output logic                                   qhv_valid_o,
    output logic [HVDimension-1:0]                 qhv_o,
    output logic [FifoCntWidth-1:0]                qhv_fifo_cnt_o,
    output logic                                   qhv_stall_o,
    output logic                                   qhv_overflow_o
);

    localparam logic [BundCountWidth-1:0] CntOne = BundCountWidth'(1);
    localparam logic [BundCountWidth-1:0] CntMax = '1;
    localparam logic [BundCountWidth-1:0] AccMax = {1'b0, {(BundCountWidth-1){1'b1}}};
    localparam logic [BundCountWidth-1:0] AccMin = {1'b1, {(BundCountWidth-1){1'b0}}};

    // Per-bit signed vote accumulators; the binarized bit is set when positive
    logic [BundCountWidth-1:0] acc_q [NumBund][HVDimension];
    logic [BundCountWidth-1:0] acc_d [NumBund][HVDimension];
    logic [NumBund-1:0][BundCountWidth-1:0] cnt_q, cnt_d;
    logic [HVDimension-1:0] rf_q [RegNum];
    logic [HVDimension-1:0] rf_d [RegNum];
    logic emit_pending_q, emit_pending_d, overflow_q, overflow_d;
    logic [BundSelWidth-1:0] emit_sel_q, emit_sel_d;

    logic [NumBund-1:0][HVDimension-1:0] bund_out, bund_in;
    logic [HVDimension-1:0] alu_a, alu_b, alu_out, reg_a, reg_b, reg_wdata, qhv_src, fifo_wdata;
    logic [2*HVDimension-1:0] rot;
    logic [NumBund-1:0] bund_accept, bund_clear;
    logic fifo_full, fifo_empty, fifo_drop, fifo_push, stall, auto_fire, viol, emit_set;

    assign reg_a       = rf_q[reg_rd_addr_a_i];
    assign reg_b       = rf_q[reg_rd_addr_b_i];
    // Stall depends only on registered state, so the controller sees no input path
    assign stall       = fifo_full || emit_pending_q;
    assign auto_fire   = emit_pending_q && !qhv_clr_i;
    assign fifo_push   = auto_fire || (qhv_wen_i && !stall);
    assign fifo_wdata  = auto_fire ? bund_out[emit_sel_q] : qhv_src;
    assign qhv_valid_o = !fifo_empty;
    assign qhv_stall_o = stall;
    assign qhv_overflow_o = overflow_q;

    // Binarize bundler accumulators
    always_comb begin
        bund_out = '0;
        for (int k = 0; k < NumBund; k++)
            for (int i = 0; i < HVDimension; i++)
                bund_out[k][i] = !acc_q[k][i][BundCountWidth-1] && (acc_q[k][i] != '0);
    end

    // Source multiplexers; any unmapped select produces zeros
    always_comb begin
        alu_a = '0; alu_b = '0; reg_wdata = '0; qhv_src = '0; bund_in = '0;
        if (int'(alu_mux_a_i) == ALU_SRC_IM)  alu_a = im_rd_a_i;
        if (int'(alu_mux_a_i) == ALU_SRC_REG) alu_a = reg_a;
        if (int'(alu_mux_b_i) == ALU_SRC_IM)  alu_b = im_rd_b_i;
        if (int'(alu_mux_b_i) == ALU_SRC_REG) alu_b = reg_b;
        if (int'(reg_mux_i) == REG_SRC_ALU)   reg_wdata = alu_out;
        if (int'(reg_mux_i) == REG_SRC_IM)    reg_wdata = im_rd_a_i;
        if (int'(qhv_mux_i) == QHV_SRC_ALU)   qhv_src = alu_out;
        if (int'(qhv_mux_i) == QHV_SRC_REG)   qhv_src = reg_a;
        for (int k = 0; k < NumBund; k++) begin
            if (int'(alu_mux_a_i) == ALU_SRC_BUND_BASE + k) alu_a = bund_out[k];
            if (int'(alu_mux_b_i) == ALU_SRC_BUND_BASE + k) alu_b = bund_out[k];
            if (int'(reg_mux_i) == REG_SRC_BUND_BASE + k)   reg_wdata = bund_out[k];
            if (int'(qhv_mux_i) == QHV_SRC_BUND_BASE + k)   qhv_src = bund_out[k];
            if (int'(bund_mux_i[k]) == BUND_SRC_ALU) bund_in[k] = alu_out;
            if (int'(bund_mux_i[k]) == BUND_SRC_IM)  bund_in[k] = im_rd_a_i;
            if (int'(bund_mux_i[k]) == BUND_SRC_REG) bund_in[k] = reg_a;
            for (int j = 0; j < NumBund; j++)
                if (int'(bund_mux_i[k]) == BUND_SRC_BUND_BASE + j) bund_in[k] = bund_out[j];
        end
    end

    // ALU: bitwise ops plus circular left rotate of A
    always_comb begin
        alu_out = '0;
        rot     = {alu_a, alu_a} << (int'(alu_shift_amt_i) % HVDimension);
        case (alu_op_e'(alu_ops_i))
            ALU_OP_XOR:  alu_out = alu_a ^ alu_b;
            ALU_OP_AND:  alu_out = alu_a & alu_b;
            ALU_OP_OR:   alu_out = alu_a | alu_b;
            ALU_OP_PERM: alu_out = rot[2*HVDimension-1 -: HVDimension];
            default:     alu_out = '0;
        endcase
    end

    // Bundler accumulate/clear, sample counts, auto-emit trigger and overflow
    always_comb begin
        acc_d = acc_q; cnt_d = cnt_q; bund_accept = '0; bund_clear = '0;
        viol = 1'b0; emit_set = 1'b0;
        for (int k = 0; k < NumBund; k++) begin
            bund_clear[k]  = bund_clr_i[k] || (auto_fire && int'(emit_sel_q) == k);
            bund_accept[k] = bund_valid_i[k] && !(stall && int'(auto_emit_sel_i) == k);
            if (bund_valid_i[k] && !bund_accept[k]) viol = 1'b1;
            if (bund_clear[k]) begin
                cnt_d[k] = '0;
                for (int i = 0; i < HVDimension; i++) acc_d[k][i] = '0;
            end else if (bund_accept[k]) begin
                if (cnt_q[k] != CntMax) cnt_d[k] = cnt_q[k] + CntOne;
                for (int i = 0; i < HVDimension; i++) begin
                    if (bund_in[k][i]) begin
                        if (acc_q[k][i] != AccMax) acc_d[k][i] = acc_q[k][i] + CntOne;
                    end else if (acc_q[k][i] != AccMin) begin
                        acc_d[k][i] = acc_q[k][i] - CntOne;
                    end
                end
            end
            if (int'(auto_emit_sel_i) == k && bund_accept[k] && !bund_clear[k] && auto_emit_en_i
                && auto_emit_count_i != '0 && cnt_d[k] == auto_emit_count_i)
                emit_set = 1'b1;
        end
        emit_pending_d = emit_set && !qhv_clr_i;
        emit_sel_d     = emit_set ? auto_emit_sel_i : emit_sel_q;
        overflow_d     = qhv_clr_i ? 1'b0
                       : (overflow_q || fifo_drop || viol || (qhv_wen_i && stall));
    end

    // Register file write
    always_comb begin
        rf_d = rf_q;
        if (reg_wr_en_i) rf_d[reg_wr_addr_i] = reg_wdata;
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumBund; k++)
                for (int i = 0; i < HVDimension; i++) acc_q[k][i] <= '0;
            for (int r = 0; r < RegNum; r++) rf_q[r] <= '0;
            cnt_q          <= '0;
            emit_pending_q <= 1'b0;
            emit_sel_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            rf_q           <= rf_d;
            cnt_q          <= cnt_d;
            emit_pending_q <= emit_pending_d;
            emit_sel_q     <= emit_sel_d;
            overflow_q     <= overflow_d;
        end
    end

    hv_qhv_fifo #(
        .Depth    (QhvFifoDepth),
        .Width    (HVDimension),
        .CntWidth (FifoCntWidth)
    ) u_qhv_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (qhv_ready_i),
        .clr_i   (qhv_clr_i),
        .data_i  (fifo_wdata),
        .data_o  (qhv_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (qhv_fifo_cnt_o),
        .drop_o  (fifo_drop)
    );

endmodule

// File: tb/tb_hv_encoder_mc.sv
// Directed bench for hv_encoder_mc at HVDimension=8 with a spec-level model
// (sample vote counts, FIFO queue) checked on every cycle.
module tb_hv_encoder_mc;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] im_a, im_b;
    logic [2:0] alu_mux_a, alu_mux_b;
    logic [1:0] alu_op;
    logic [6:0] shift_amt;
    logic [3:0][2:0] bund_mux;
    logic [3:0] bund_valid, bund_clr;
    logic [2:0] reg_mux;
    logic [1:0] rd_a, rd_b, wr_addr;
    logic reg_wr_en, qhv_wen, qhv_clr, emit_en, qhv_ready;
    logic [2:0] qhv_mux;
    logic [1:0] emit_sel;
    logic [7:0] emit_count;
    logic qhv_valid_o, qhv_stall_o, qhv_overflow_o;
    logic [7:0] qhv_o;
    logic [2:0] qhv_fifo_cnt_o;

    int n_pass = 0;
    int n_total = 0;

    // Spec-level model state
    logic [7:0] m_rf [4];
    int m_ones [4][8];
    int m_n [4];
    logic [7:0] m_bo [4];
    bit m_pend;
    int m_psel;
    logic [7:0] m_q [$];
    bit m_ovf;
    logic [7:0] m_last;

    always #5 clk = ~clk;

    hv_encoder_mc #(.HVDimension(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .im_rd_a_i(im_a), .im_rd_b_i(im_b),
        .alu_mux_a_i(alu_mux_a), .alu_mux_b_i(alu_mux_b), .alu_ops_i(alu_op),
        .alu_shift_amt_i(shift_amt), .bund_mux_i(bund_mux), .bund_valid_i(bund_valid),
        .bund_clr_i(bund_clr), .reg_mux_i(reg_mux), .reg_rd_addr_a_i(rd_a),
        .reg_rd_addr_b_i(rd_b), .reg_wr_addr_i(wr_addr), .reg_wr_en_i(reg_wr_en),
        .qhv_mux_i(qhv_mux), .qhv_wen_i(qhv_wen), .qhv_clr_i(qhv_clr),
        .auto_emit_en_i(emit_en), .auto_emit_sel_i(emit_sel), .auto_emit_count_i(emit_count),
        .qhv_ready_i(qhv_ready), .qhv_valid_o(qhv_valid_o), .qhv_o(qhv_o),
        .qhv_fifo_cnt_o(qhv_fifo_cnt_o), .qhv_stall_o(qhv_stall_o),
        .qhv_overflow_o(qhv_overflow_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Bit-wise majority of the samples bundled so far (ties read as 0)
    function automatic logic [7:0] majority(input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (2 * m_ones[k][i] > m_n[k]);
        return r;
    endfunction

    // Fixed sources first, then bundler outputs, anything beyond is zero
    function automatic logic [7:0] pick(input int sel, input int nfixed,
                                        input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        logic [7:0] r;
        r = 8'h00;
        if (sel == 0) r = s0;
        else if (sel == 1 && nfixed > 1) r = s1;
        else if (sel == 2 && nfixed > 2) r = s2;
        else if (sel >= nfixed && sel - nfixed < 4) r = m_bo[sel - nfixed];
        return r;
    endfunction

    task automatic idle();
        im_a = 8'h00; im_b = 8'h00; alu_mux_a = 3'd0; alu_mux_b = 3'd0; alu_op = 2'd0;
        shift_amt = 7'd0; bund_mux = '0; bund_valid = 4'b0; bund_clr = 4'b0; reg_mux = 3'd0;
        rd_a = 2'd0; rd_b = 2'd0; wr_addr = 2'd0; reg_wr_en = 1'b0; qhv_mux = 3'd0;
        qhv_wen = 1'b0; qhv_clr = 1'b0; emit_en = 1'b0; emit_sel = 2'd0; emit_count = 8'd0;
        qhv_ready = 1'b0;
    endtask

    // Model: advance one clock from the spec's rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++) m_rf[r] = 8'h00;
            for (int k = 0; k < 4; k++) begin
                m_n[k] = 0;
                for (int i = 0; i < 8; i++) m_ones[k][i] = 0;
            end
            m_pend = 1'b0; m_psel = 0; m_q.delete(); m_ovf = 1'b0; m_last = 8'h00;
        end else begin
            logic [7:0] a, b, alu, ra, rb, pv, rw;
            logic [7:0] bin [4];
            bit stall, fire, push, full_pre, set, clrk, blk, acc;
            for (int k = 0; k < 4; k++) m_bo[k] = majority(k);
            ra = m_rf[rd_a]; rb = m_rf[rd_b];
            a = pick(int'(alu_mux_a), 2, im_a, ra, 8'h00);
            b = pick(int'(alu_mux_b), 2, im_b, rb, 8'h00);
            case (alu_op)
                2'd0: alu = a ^ b;
                2'd1: alu = a & b;
                2'd2: alu = a | b;
                default: for (int i = 0; i < 8; i++) alu[(i + int'(shift_amt)) % 8] = a[i];
            endcase
            for (int k = 0; k < 4; k++) bin[k] = pick(int'(bund_mux[k]), 3, alu, im_a, ra);
            rw = pick(int'(reg_mux), 2, alu, im_a, 8'h00);
            stall = (m_q.size() == 4) || m_pend;
            fire = m_pend && !qhv_clr;
            if (m_q.size() > 0) m_last = m_q[0];
            push = 1'b0; pv = 8'h00;
            if (fire) begin push = 1'b1; pv = m_bo[m_psel]; end
            else if (qhv_wen && !stall) begin push = 1'b1; pv = pick(int'(qhv_mux), 2, alu, ra, 8'h00); end
            if (qhv_wen && stall) m_ovf = 1'b1;
            if (qhv_clr) m_q.delete();
            else begin
                full_pre = (m_q.size() == 4);
                if (qhv_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (push) begin
                    if (full_pre) m_ovf = 1'b1;
                    else m_q.push_back(pv);
                end
            end
            set = 1'b0;
            for (int k = 0; k < 4; k++) begin
                clrk = bund_clr[k] || (fire && k == m_psel);
                blk = stall && k == int'(emit_sel);
                acc = bund_valid[k] && !blk;
                if (bund_valid[k] && blk) m_ovf = 1'b1;
                if (clrk) begin
                    m_n[k] = 0;
                    for (int i = 0; i < 8; i++) m_ones[k][i] = 0;
                end else if (acc) begin
                    if (m_n[k] < 255) m_n[k]++;
                    for (int i = 0; i < 8; i++) m_ones[k][i] += int'(bin[k][i]);
                end
                if (k == int'(emit_sel) && acc && !clrk && emit_en && emit_count != 8'd0
                    && m_n[k] == int'(emit_count)) set = 1'b1;
            end
            m_pend = set && !qhv_clr;
            if (set) m_psel = int'(emit_sel);
            if (qhv_clr) m_ovf = 1'b0;
            if (reg_wr_en) m_rf[wr_addr] = rw;
        end
    end

    // Compare DUT against the model every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(qhv_valid_o), 32'(m_q.size() > 0));
            check("count", 32'(qhv_fifo_cnt_o), 32'(m_q.size()));
            check("stall", 32'(qhv_stall_o), 32'((m_q.size() == 4) || m_pend));
            check("overflow", 32'(qhv_overflow_o), 32'(m_ovf));
            check("data", 32'(qhv_o), 32'(m_q.size() > 0 ? m_q[0] : m_last));
        end
    end

    initial begin
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(qhv_valid_o), 32'h0);
        check("rst_data", 32'(qhv_o), 32'h0);
        check("rst_count", 32'(qhv_fifo_cnt_o), 32'h0);
        check("rst_stall", 32'(qhv_stall_o), 32'h0);
        check("rst_overflow", 32'(qhv_overflow_o), 32'h0);
        rst_n = 1'b1;

        // Auto-emit after three samples on bundler 1
        emit_en = 1'b1; emit_count = 8'd3; emit_sel = 2'd1; bund_mux[1] = 3'd1;
        bund_valid = 4'b0010; im_a = 8'hCA;
        @(negedge clk); im_a = 8'h8E;
        @(negedge clk); im_a = 8'h5A;
        @(negedge clk); bund_valid = 4'b0;
        check("emit_stall", 32'(qhv_stall_o), 32'h1);
        @(negedge clk);
        check("emit_count", 32'(qhv_fifo_cnt_o), 32'h1);
        check("emit_head", 32'(qhv_o), 32'hCA);
        check("emit_unstall", 32'(qhv_stall_o), 32'h0);
        qhv_mux = 3'd3; qhv_wen = 1'b1;
        @(negedge clk); qhv_wen = 1'b0; qhv_ready = 1'b1;
        check("bund1_push_count", 32'(qhv_fifo_cnt_o), 32'h2);
        @(negedge clk);
        check("bund1_cleared", 32'(qhv_o), 32'h00);
        @(negedge clk);
        check("drained_valid", 32'(qhv_valid_o), 32'h0);
        idle();

        // Fill with four manual pushes, then overflow, then full push+pop
        for (int i = 0; i < 4; i++) begin
            im_a = pat[i]; qhv_wen = 1'b1;
            @(negedge clk);
        end
        check("full_count", 32'(qhv_fifo_cnt_o), 32'h4);
        check("full_stall", 32'(qhv_stall_o), 32'h1);
        im_a = 8'h55;
        @(negedge clk);
        check("ovf_set", 32'(qhv_overflow_o), 32'h1);
        check("ovf_head", 32'(qhv_o), 32'h11);
        im_a = 8'h66; qhv_ready = 1'b1;
        @(negedge clk);
        check("full_pushpop_count", 32'(qhv_fifo_cnt_o), 32'h3);
        check("full_pushpop_head", 32'(qhv_o), 32'h22);
        qhv_wen = 1'b0;
        repeat (3) @(negedge clk);
        check("held_head", 32'(qhv_o), 32'h44);
        qhv_ready = 1'b0; qhv_clr = 1'b1;
        @(negedge clk); qhv_clr = 1'b0;
        check("clr_ovf", 32'(qhv_overflow_o), 32'h0);
        idle();

        // Chaining: bundler 1 -> bundler 0, ALU on bundler 1, register round-trip
        bund_mux[1] = 3'd1; bund_valid = 4'b0010; im_a = 8'hA5;
        @(negedge clk);
        bund_valid = 4'b0001; bund_mux[0] = 3'd4; alu_mux_a = 3'd3; alu_mux_b = 3'd0;
        im_b = 8'hFF; alu_op = 2'd0; reg_mux = 3'd0; reg_wr_en = 1'b1; wr_addr = 2'd2;
        @(negedge clk);
        bund_valid = 4'b0; reg_wr_en = 1'b0; rd_a = 2'd2; qhv_mux = 3'd1; qhv_wen = 1'b1;
        @(negedge clk); qhv_mux = 3'd2;
        @(negedge clk); qhv_mux = 3'd0; alu_mux_a = 3'd0; im_a = 8'h81; alu_op = 2'd3; shift_amt = 7'd1;
        @(negedge clk); qhv_mux = 3'd6;
        @(negedge clk); qhv_wen = 1'b0;
        check("chain_count", 32'(qhv_fifo_cnt_o), 32'h4);
        check("chain_reg", 32'(qhv_o), 32'h5A);
        qhv_ready = 1'b1;
        @(negedge clk); check("chain_bund0", 32'(qhv_o), 32'hA5);
        @(negedge clk); check("chain_rotate", 32'(qhv_o), 32'h03);
        @(negedge clk); check("chain_oor_zero", 32'(qhv_o), 32'h00);
        @(negedge clk); idle();

        // Flush while an emit is pending
        qhv_wen = 1'b1; im_a = 8'h0F;
        @(negedge clk); im_a = 8'hF0;
        @(negedge clk); qhv_wen = 1'b0;
        emit_en = 1'b1; emit_count = 8'd2; emit_sel = 2'd2; bund_mux[2] = 3'd1;
        bund_valid = 4'b0100; im_a = 8'h3C;
        repeat (2) @(negedge clk);
        check("pend_stall", 32'(qhv_stall_o), 32'h1);
        bund_valid = 4'b0; qhv_clr = 1'b1; qhv_wen = 1'b1;
        @(negedge clk); qhv_clr = 1'b0; qhv_wen = 1'b0;
        check("flush_count", 32'(qhv_fifo_cnt_o), 32'h0);
        check("flush_valid", 32'(qhv_valid_o), 32'h0);
        check("flush_ovf", 32'(qhv_overflow_o), 32'h0);
        @(negedge clk);
        check("flush_no_push", 32'(qhv_fifo_cnt_o), 32'h0);
        idle();

        // Asynchronous reset in the middle of an emit
        qhv_wen = 1'b1; im_a = 8'h01;
        @(negedge clk); im_a = 8'h02;
        @(negedge clk); qhv_wen = 1'b0;
        emit_en = 1'b1; emit_count = 8'd1; emit_sel = 2'd3; bund_mux[3] = 3'd1;
        bund_valid = 4'b1000; im_a = 8'hF0;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("arst_count", 32'(qhv_fifo_cnt_o), 32'h0);
        check("arst_valid", 32'(qhv_valid_o), 32'h0);
        check("arst_stall", 32'(qhv_stall_o), 32'h0);
        check("arst_data", 32'(qhv_o), 32'h0);
        @(negedge clk); idle(); rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_emit", 32'(qhv_fifo_cnt_o), 32'h0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hv_encoder_mc.md
Name: hv_encoder_mc

Overview:
Next-generation hypervector encoder datapath with a parametrised number of bundlers and a register file. It adds an output query-HV FIFO with a valid/ready handshake and an auto-emit mode: a selected bundler's result is pushed automatically once a programmed number of HVs has been bundled, and that bundler is then cleared. It sits between the item memory and the associative memory, driven by the encoder controller.

Parameters:
HVDimension, 512, hypervector width in bits
NumBund, 4, number of bundler units (2..8)
BundCountWidth, 8, bundler counter width; also the width of the per-bundler sample count
RegNum, 4, HV register file depth
ALUMaxShiftAmt, 128, maximum ALU permute shift
QhvFifoDepth, 4, output FIFO depth (power of 2, at least 2)
NumALUOps, 4, ALU operation count (fixed)
Derived: ALUMuxWidth=$clog2(2+NumBund); BundMuxWidth=$clog2(3+NumBund); RegMuxWidth=QvMuxWidth=$clog2(2+NumBund); RegAddrWidth=$clog2(RegNum); BundSelWidth=$clog2(NumBund); FifoCntWidth=$clog2(QhvFifoDepth)+1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
im_rd_a_i / im_rd_b_i  in  HVDimension  item memory read data
alu_mux_a_i / alu_mux_b_i  in  ALUMuxWidth  ALU operand selects
alu_ops_i  in  $clog2(NumALUOps)  ALU operation
alu_shift_amt_i  in  $clog2(ALUMaxShiftAmt)  permute amount
bund_mux_i  in  NumBund x BundMuxWidth  per-bundler input select
bund_valid_i  in  NumBund  per-bundler accumulate strobe
bund_clr_i  in  NumBund  per-bundler clear
reg_mux_i  in  RegMuxWidth  register write-data select
reg_rd_addr_a_i / reg_rd_addr_b_i / reg_wr_addr_i  in  RegAddrWidth  register addresses
reg_wr_en_i  in  1  register write enable
qhv_mux_i  in  QvMuxWidth  manual push source
qhv_wen_i  in  1  manual FIFO push
qhv_clr_i  in  1  flush FIFO and clear overflow
auto_emit_en_i  in  1  enable auto-emit
auto_emit_sel_i  in  BundSelWidth  bundler watched by auto-emit
auto_emit_count_i  in  BundCountWidth  samples per emitted HV; 0 means never emit
qhv_ready_i  in  1  downstream ready
qhv_valid_o  out  1  FIFO head valid
qhv_o  out  HVDimension  FIFO head data
qhv_fifo_cnt_o  out  FifoCntWidth  FIFO occupancy
qhv_stall_o  out  1  controller must hold push and bundle commands
qhv_overflow_o  out  1  sticky: a push was dropped

Behaviour:
- Mux maps:
  - ALU A: 0 im_a, 1 reg_a, 2+k bundler k.
  - ALU B: 0 im_b, 1 reg_b, 2+k bundler k.
  - Bundler k input: 0 alu_out, 1 im_a, 2 reg_a, 3+j bundler j.
  - Register write data: 0 alu_out, 1 im_a, 2+k bundler k.
  - QHV push source: 0 alu_out, 1 reg_a, 2+k bundler k.
  - Any out-of-range select yields all zeros.
- Bundlers reuse the existing bundler_set; the binarized output reflects an accepted sample one cycle after bund_valid_i.
- Per-bundler sample count cnt[k]:
  - Increments on each accepted bund_valid_i[k] and saturates at its maximum.
  - Zeroed by bund_clr_i[k] or an auto-clear; clear has priority over valid.
- Auto-emit: when auto_emit_en_i=1, count!=0, and a valid on bundler s=auto_emit_sel_i makes cnt[s]==count, emit_pending is set. In the next cycle:
  - bundler s output is pushed to the FIFO;
  - bundler s is cleared and cnt[s] zeroed;
  - emit_pending drops.
- qhv_stall_o = fifo_full | emit_pending, registered-state derived with no input path. While stall is high, a qhv_wen_i or a bund_valid_i to the selected bundler is a protocol violation; the block ignores it and sets qhv_overflow_o.
- Push arbitration: an auto push has priority. A manual push is accepted only when stall=0.
- FIFO:
  - The head is visible on qhv_o while qhv_valid_o=1; pop on valid&ready.
  - Full is evaluated before the pop, so a push in a full cycle is dropped even if a pop occurs; overflow is set.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
  - qhv_o is held at the last head value when the FIFO is empty.
- qhv_clr_i empties the FIFO, clears overflow and cancels emit_pending in the same edge; it has priority over push.
- Reset: all FIFO entries, qhv_o, qhv_valid_o, qhv_fifo_cnt_o, qhv_stall_o, qhv_overflow_o, counts, emit_pending, register file and bundlers go to 0. Reset asserted mid-emit discards the pending push.

Decomposition:
- Package hv_encoder_pkg: mux-select localparams/enums for fixed sources (ALU_SRC_IM, ALU_SRC_REG, BUND_SRC_ALU, ...), bundler select-base offsets, NumALUOps.
- Sub-module hv_qhv_fifo: parametrised depth/width; push/pop/clr; full, empty and count outputs; drop-on-full flag.
- Reuse mux, reg_file_1w2r, hv_alu_pe and bundler_set.

Test Plan:
- Reset → qhv_valid_o=0, qhv_o=0, qhv_fifo_cnt_o=0, qhv_stall_o=0, qhv_overflow_o=0.
- HVDimension=8, auto_emit_count=3, sel=1; bundle 8'b11001010, 8'b10001110, 8'b01011010 via im_a → one cycle after the third valid, stall=1. The next cycle, FIFO holds 8'b11001010 (majority), cnt[1]=0, and bundler 1 output=0.
- Manual pushes of 4 HVs with qhv_ready_i=0 and depth 4 → cnt=4, stall=1. A 5th wen is dropped, overflow=1, and the head is still the first HV.
- FIFO full with ready=1 and wen=1 in the same cycle → pop occurs, push is dropped, cnt=3.
- Bundler chaining: bundler 0 input=3+1 (bundler 1 output), alu_mux_a=2+1 with XOR against im_b=8'hFF → alu_out=~bundler1; register write via reg_mux=0 then read back matches.
- qhv_clr_i during emit_pending with 2 entries → cnt=0, valid=0, no push next cycle, overflow=0; async reset mid-stream clears within the same cycle.
